fifo_rptr_empty: RTL and testbench
==================================

// Module: fifo_rptr_empty
// PURPOSE
//   Read-side pointer and empty-flag generator for the asynchronous FIFO.
//   Consumes the write pointer after it crosses into the read domain through the
//   2-FF synchronizer. Produces the read address for the dual-port memory and the
//   Gray read pointer that crosses back to the write domain.
//   Also reports empty, almost-empty, read-side fill level and sticky underflow.
// PARAMETERS
//   WIDTH          3  memory address bits; pointers are WIDTH+1 bits [WIDTH:0]
//   AEMPTY_THRESH  2  almost_empty asserts when rlevel <= this value
// PORTS
//   clk           in   1        read-domain clock, rising edge
//   rst           in   1        asynchronous, active-high reset
//   rd_en         in   1        read request
//   rq2_wptr      in   WIDTH+1  Gray write pointer, already synchronized to clk
//   raddr         out  WIDTH    binary read address to memory
//   rptr          out  WIDTH+1  registered Gray read pointer, to write-side synchronizer
//   empty         out  1        FIFO empty, as seen by the read side
//   almost_empty  out  1        rlevel <= AEMPTY_THRESH
//   rlevel        out  WIDTH+1  occupancy, 0..2^WIDTH
//   rd_ack        out  1        1-cycle pulse, one clock after each accepted read
//   underflow     out  1        sticky: rd_en seen while empty
// BEHAVIOUR
//   Reset values: rbin=0, rptr=0, empty=1, almost_empty=1, rlevel=0, rd_ack=0,
//   underflow=0. Reset acts immediately; no clock edge is needed.
//   Reset applied mid-operation discards any pending rd_ack.
//   rd_fire = rd_en & ~empty (combinational). Reads while empty are ignored.
//   rbin_next = rbin + rd_fire, modulo 2^(WIDTH+1). Wrap from all-ones to 0 is legal.
//   rgray_next = rbin_next ^ (rbin_next >> 1). Each edge: rbin<=rbin_next, rptr<=rgray_next.
//   raddr = rbin[WIDTH-1:0] (registered binary; the MSB is the wrap bit).
//   empty <= (rgray_next == rq2_wptr). Comparison is Gray-to-Gray, all WIDTH+1 bits.
//   wbin = Gray-to-binary of rq2_wptr (combinational XOR prefix).
//   rlevel <= wbin - rbin_next, modulo 2^(WIDTH+1). Max is 2^WIDTH when full.
//   almost_empty <= (wbin - rbin_next) <= AEMPTY_THRESH.
//   rd_ack <= rd_fire. Aligns with synchronous-read memory data.
//   underflow <= underflow | (rd_en & empty). Cleared only by rst.
//   Synchronizer latency makes empty/rlevel pessimistic:
//   - empty may stay high 2-3 clks after a write; this is correct behaviour.
//   - The flags never report data that has not been written.
//   rq2_wptr must change by at most one Gray bit per clk; the block does not check this.
//   A read and a wptr advance in the same cycle are both accounted for in that
//   cycle's rlevel/empty update.
// TESTING  (WIDTH=3, AEMPTY_THRESH=2)
//   1 rst=1, rq2_wptr=0 -> without a clk edge: empty=1, almost_empty=1, rptr=0,
//     raddr=0, rlevel=0, underflow=0.
//   2 rq2_wptr=4'b0010 (bin 3), rd_en=0 -> next edge: empty=0, rlevel=3,
//     almost_empty=0. One rd_en cycle -> rptr=4'b0001, raddr=1, rlevel=2,
//     almost_empty=1, rd_ack=1 for exactly one clk after that edge.
//   3 Continue two more reads -> rptr=4'b0010, raddr=3, empty=1, rlevel=0.
//     Then rd_en=1 for 2 clks -> rptr held, no rd_ack, underflow=1 and stays 1.
//   4 Wrap: rbin=15 (rptr=4'b1000), rq2_wptr=4'b0001 (bin 1) -> rlevel=2.
//     One read -> rptr=4'b0000, raddr=0, rlevel=1, empty=0.
//   5 Full: rbin=0, rq2_wptr=4'b1100 (bin 8) -> rlevel=8, empty=0, almost_empty=0.
//     Eight reads -> empty=1 exactly on the 8th edge.
//   6 Assert rst mid-clock while rd_en=1 and rptr=4'b0011 -> all outputs take
//     reset values immediately. No rd_ack after release until a new accepted read.

Source files
------------

// File: rtl/fifo_rptr_empty.sv
// Read-side pointer and empty/level flags for the async FIFO.
// Consumes the synchronized Gray write pointer; emits Gray read pointer.
module fifo_rptr_empty #(
  parameter int WIDTH         = 3,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [WIDTH:0]   rq2_wptr,
  output logic [WIDTH-1:0] raddr,
  output logic [WIDTH:0]   rptr,
  output logic             empty,
  output logic             almost_empty,
  output logic [WIDTH:0]   rlevel,
  output logic             rd_ack,
  output logic             underflow
);

  localparam logic [WIDTH:0] AE_TH = (WIDTH+1)'(AEMPTY_THRESH);

  logic [WIDTH:0] rbin;
  logic [WIDTH:0] rbin_next;
  logic [WIDTH:0] rgray_next;
  logic [WIDTH:0] wbin;
  logic [WIDTH:0] lvl_next;
  logic           rd_fire;

  assign rd_fire    = rd_en & ~empty;
  assign rbin_next  = rbin + {{WIDTH{1'b0}}, rd_fire};
  assign rgray_next = rbin_next ^ (rbin_next >> 1);

  // Gray to binary: each bit is the XOR of itself and all higher bits
  always_comb begin
    wbin = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      wbin[i] = ^(rq2_wptr >> i);
    end
  end

  assign lvl_next = wbin - rbin_next;
  assign raddr    = rbin[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rbin         <= '0;
      rptr         <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rlevel       <= '0;
      rd_ack       <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      rbin         <= rbin_next;
      rptr         <= rgray_next;
      empty        <= (rgray_next == rq2_wptr);
      almost_empty <= (lvl_next <= AE_TH);
      rlevel       <= lvl_next;
      rd_ack       <= rd_fire;
      underflow    <= underflow | (rd_en & empty);
    end
  end

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Randomized scoreboard bench for fifo_rptr_empty.
// Model counts total reads/writes as plain integers.
module tb_fifo_rptr_empty;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         rd_en = 1'b0;
  logic [W:0]   rq2_wptr = '0;
  logic [W-1:0] raddr;
  logic [W:0]   rptr;
  logic         empty;
  logic         almost_empty;
  logic [W:0]   rlevel;
  logic         rd_ack;
  logic         underflow;

  fifo_rptr_empty #(.WIDTH(W), .AEMPTY_THRESH(2)) dut (
    .clk(clk),
    .rst(rst),
    .rd_en(rd_en),
    .rq2_wptr(rq2_wptr),
    .raddr(raddr),
    .rptr(rptr),
    .empty(empty),
    .almost_empty(almost_empty),
    .rlevel(rlevel),
    .rd_ack(rd_ack),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] raddr;
    logic [W:0]   rptr;
    logic         empty;
    logic         ae;
    logic [W:0]   rlevel;
    logic         ack;
    logic         uf;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  int unsigned rcnt;
  int unsigned wcnt;
  logic        m_empty;
  logic        m_uf;

  function automatic logic [W:0] to_gray(int unsigned b);
    logic [W:0] x;
    x = b[W:0];
    return x ^ (x >> 1);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rcnt     = 0;
    wcnt     = 0;
    m_empty  = 1'b1;
    m_uf     = 1'b0;
    rq2_wptr = '0;
    rd_en    = 1'b0;
  endtask

  // Called at negedge: drive inputs and queue the post-edge expectation
  task automatic step(logic rd, logic wr);
    exp_t e;
    logic fire;
    int unsigned lvl;
    if (wr && (wcnt - rcnt) < 8) wcnt++;
    rq2_wptr = to_gray(wcnt);
    rd_en    = rd;
    fire     = rd && !m_empty;
    m_uf     = m_uf | (rd && m_empty);
    if (fire) rcnt++;
    lvl      = wcnt - rcnt;
    m_empty  = (lvl == 0);
    e.raddr  = rcnt[W-1:0];
    e.rptr   = to_gray(rcnt);
    e.empty  = m_empty;
    e.ae     = (lvl <= 2);
    e.rlevel = lvl[W:0];
    e.ack    = fire;
    e.uf     = m_uf;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("raddr", raddr, e.raddr);
        chk("rptr", rptr, e.rptr);
        chk("empty", empty, e.empty);
        chk("almost_empty", almost_empty, e.ae);
        chk("rlevel", rlevel, e.rlevel);
        chk("rd_ack", rd_ack, e.ack);
        chk("underflow", underflow, e.uf);
      end
    end
  end

  task automatic chk_reset_vals(string tag);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_ae"}, almost_empty, 1);
    chk({tag, "_rptr"}, rptr, 0);
    chk({tag, "_raddr"}, raddr, 0);
    chk({tag, "_rlevel"}, rlevel, 0);
    chk({tag, "_rd_ack"}, rd_ack, 0);
    chk({tag, "_uf"}, underflow, 0);
  endtask

  initial begin : stim
    int rd_pct;
    int wr_pct;
    model_reset();
    #1 rst = 1'b1;
    #1 chk_reset_vals("rst_async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 480; i++) begin
      unique case ((i / 30) % 4)
        0: begin rd_pct = 15; wr_pct = 90; end
        1: begin rd_pct = 90; wr_pct = 15; end
        2: begin rd_pct = 50; wr_pct = 50; end
        default: begin rd_pct = 70; wr_pct = 70; end
      endcase
      @(negedge clk);
      step($urandom_range(99) < rd_pct, $urandom_range(99) < wr_pct);
    end

    // Fill a little, then issue one accepted read and reset mid-cycle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      step(1'b0, 1'b1);
    end
    @(negedge clk);
    step(1'b1, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_mid");
    @(negedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      step(1'b0, i < 3);
    end
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      step($urandom_range(99) < 50, $urandom_range(99) < 55);
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
